// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy states, bubble instruction and E/M field layout for pipeline stages
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int F_IR  = 0;
    localparam int F_PC  = 1;
    localparam int F_PC8 = 2;
    localparam int F_AO  = 3;
    localparam int F_RT  = 4;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with load enable and synchronous active-low clear
module pipe_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk)
        if (!reset) q <= '0;
        else if (ld) q <= d;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic inter-stage register with optional 2-entry skid buffer,
// flush, bubble payload on empty output and a saturating stall counter
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int           W       = 32,
    parameter int           FIELDS  = 5,
    parameter bit           SKID    = 1'b1,
    parameter int           NOP_IDX = F_IR,
    parameter logic [W-1:0] NOP_VAL = W'(NOP_INSTR),
    parameter int           STALL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W*FIELDS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W*FIELDS-1:0]   out_data,
    output logic [1:0]            occupancy,
    output logic [STALL_W-1:0]    stall_cnt
);
    localparam int DW = W * FIELDS;
    localparam logic [DW-1:0] BUBBLE = DW'(NOP_VAL) << (NOP_IDX * W);
    occ_e state, state_n;
    logic accept, emit, h_ld;
    logic [DW-1:0] h_q, s_q;
    assign out_valid = state != EMPTY;
    // With the skid buffer, ready is a decode of state only, so out_ready never reaches in_ready
    assign in_ready  = SKID ? state != TWO : !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign occupancy = state;
    assign out_data  = out_valid ? h_q : BUBBLE;
    assign h_ld      = state == EMPTY ? accept : state == ONE ? accept && emit : emit;
    always_comb begin
        state_n = flush ? EMPTY
                : state == EMPTY ? (accept ? ONE : EMPTY)
                : state == ONE ? (accept && !emit ? TWO : !accept && emit ? EMPTY : ONE)
                : (emit ? ONE : TWO);
    end
    always_ff @(posedge clk)
        state <= !reset ? EMPTY : state_n;
    always_ff @(posedge clk)
        if (!reset) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    pipe_slot #(.DW(DW)) u_head (
        .clk   (clk),
        .reset (reset),
        .ld    (h_ld),
        .d     (state == TWO ? s_q : in_data),
        .q     (h_q)
    );
    generate
        if (SKID) begin : g_skid
            pipe_slot #(.DW(DW)) u_skid (
                .clk   (clk),
                .reset (reset),
                .ld    (state == ONE && accept && !emit),
                .d     (in_data),
                .q     (s_q)
            );
        end else begin : g_noskid
            assign s_q = '0;
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: FIFO-model scoreboard plus directed checks for SKID=1 and SKID=0 stages
module tb_pipe_stage_elastic;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;
    logic flush_a, iv_a, irdy_a, ov_a, ordy_a;
    logic [159:0] id_a, od_a;
    logic [1:0] occ_a;
    logic [3:0] sc_a;
    logic flush_b, iv_b, irdy_b, ov_b, ordy_b;
    logic [31:0] id_b, od_b;
    logic [1:0] occ_b;
    logic [15:0] sc_b;
    int vecs = 0, errs = 0;
    bit chk_en = 1'b0;
    logic [159:0] mq [2][2];
    int mc [2] = '{0, 0};
    int ms [2] = '{0, 0};

    pipe_stage_elastic #(.W(32), .FIELDS(5), .SKID(1'b1), .STALL_W(4)) dut_a (
        .clk(clk), .reset(reset), .flush(flush_a), .in_valid(iv_a), .in_ready(irdy_a),
        .in_data(id_a), .out_valid(ov_a), .out_ready(ordy_a), .out_data(od_a),
        .occupancy(occ_a), .stall_cnt(sc_a)
    );
    pipe_stage_elastic #(.W(16), .FIELDS(2), .SKID(1'b0), .STALL_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(flush_b), .in_valid(iv_b), .in_ready(irdy_b),
        .in_data(id_b), .out_valid(ov_b), .out_ready(ordy_b), .out_data(od_b),
        .occupancy(occ_b), .stall_cnt(sc_b)
    );

    // Model: a plain FIFO of capacity 2 (registered ready) or 1 (ready when empty or draining)
    function automatic bit exp_rdy(int i);
        return i == 0 ? mc[0] < 2 : (mc[1] == 0 || ordy_b);
    endfunction
    function automatic logic [159:0] mk(input logic [31:0] ir);
        return {ir ^ 32'h4, ir ^ 32'h3, ir ^ 32'h2, ir ^ 32'h1, ir};
    endfunction
    task automatic chk(input string n, input int i, input logic [159:0] act, input logic [159:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0h expected %0h", n, i, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        bit v, r, f, rdy;
        logic [159:0] d;
        int mx;
        for (int i = 0; i < 2; i++) begin
            v   = i == 0 ? iv_a : iv_b;
            r   = i == 0 ? ordy_a : ordy_b;
            f   = i == 0 ? flush_a : flush_b;
            d   = i == 0 ? id_a : {128'b0, id_b};
            mx  = i == 0 ? 15 : 65535;
            rdy = exp_rdy(i);
            if (!reset) begin
                mc[i] = 0;
                ms[i] = 0;
            end else begin
                if (mc[i] > 0 && !r && ms[i] < mx) ms[i]++;
                if (f) mc[i] = 0;
                else begin
                    if (mc[i] > 0 && r) begin
                        mq[i][0] = mq[i][1];
                        mc[i]--;
                    end
                    if (v && rdy) begin
                        mq[i][mc[i]] = d;
                        mc[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("out_valid", i, 160'(i == 0 ? ov_a : ov_b), 160'(mc[i] > 0));
                chk("out_data", i, i == 0 ? od_a : {128'b0, od_b}, mc[i] > 0 ? mq[i][0] : '0);
                chk("in_ready", i, 160'(i == 0 ? irdy_a : irdy_b), 160'(exp_rdy(i)));
                chk("occupancy", i, 160'(i == 0 ? occ_a : occ_b), 160'(mc[i]));
                chk("stall_cnt", i, i == 0 ? 160'(sc_a) : 160'(sc_b), 160'(ms[i]));
            end
        end
    end

    initial begin
        logic [31:0] ir;
        reset = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
        iv_a = 1'b1; iv_b = 1'b1; ordy_a = 1'b1; ordy_b = 1'b1;
        id_a = mk(32'hDEAD_0001); id_b = 32'h1111_2222;
        step();
        chk_en = 1'b1;
        step();
        step();
        chk("rst_valid", 0, 160'(ov_a), 160'(0));
        chk("rst_ir", 0, 160'(od_a[31:0]), 160'(0));
        chk("rst_occ", 0, 160'(occ_a), 160'(0));
        chk("rst_stall", 0, 160'(sc_a), 160'(0));
        chk("rst_valid", 1, 160'(ov_b), 160'(0));
        reset = 1'b1; iv_a = 1'b0; iv_b = 1'b0;
        #1;
        chk("rel_ready", 0, 160'(irdy_a), 160'(1));
        chk("rel_ready", 1, 160'(irdy_b), 160'(1));
        for (int k = 0; k < 4; k++) begin
            ir = 32'h8C01_0004 + 32'(4 * k);
            iv_a = 1'b1; id_a = mk(ir);
            step();
            chk("stream_ir", 0, 160'(od_a[31:0]), 160'(ir));
            chk("stream_occ", 0, 160'(occ_a), 160'(1));
            chk("stream_ready", 0, 160'(irdy_a), 160'(1));
        end
        iv_a = 1'b0;
        step();
        chk("stream_drain", 0, 160'(ov_a), 160'(0));
        ordy_a = 1'b0; iv_a = 1'b1; id_a = mk(32'hA);
        step();
        id_a = mk(32'hB);
        step();
        chk("bp_occ2", 0, 160'(occ_a), 160'(2));
        chk("bp_ready0", 0, 160'(irdy_a), 160'(0));
        chk("bp_headA", 0, 160'(od_a[31:0]), 160'(32'hA));
        id_a = mk(32'hC);
        step();
        chk("bp_holdA", 0, od_a, mk(32'hA));
        chk("bp_holdocc", 0, 160'(occ_a), 160'(2));
        ordy_a = 1'b1;
        step();
        chk("bp_B", 0, 160'(od_a[31:0]), 160'(32'hB));
        chk("bp_B_occ", 0, 160'(occ_a), 160'(1));
        step();
        chk("bp_C", 0, 160'(od_a[31:0]), 160'(32'hC));
        iv_a = 1'b0;
        step();
        chk("bp_empty", 0, 160'(ov_a), 160'(0));
        ordy_a = 1'b0; iv_a = 1'b1; id_a = mk(32'hD);
        step();
        id_a = mk(32'hE);
        step();
        chk("fl_occ2", 0, 160'(occ_a), 160'(2));
        id_a = mk(32'hF); flush_a = 1'b1;
        step();
        flush_a = 1'b0; iv_a = 1'b0;
        chk("fl_valid", 0, 160'(ov_a), 160'(0));
        chk("fl_occ", 0, 160'(occ_a), 160'(0));
        chk("fl_ir", 0, 160'(od_a[31:0]), 160'(0));
        ordy_a = 1'b1;
        step();
        step();
        chk("fl_nothing", 0, 160'(ov_a), 160'(0));
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("st_clear", 0, 160'(sc_a), 160'(0));
        ordy_a = 1'b0; iv_a = 1'b1; id_a = mk(32'h6);
        step();
        iv_a = 1'b0;
        repeat (20) step();
        chk("st_sat", 0, 160'(sc_a), 160'(15));
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        chk("st_flush", 0, 160'(sc_a), 160'(15));
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("st_reset", 0, 160'(sc_a), 160'(0));
        ordy_b = 1'b0; iv_b = 1'b1; id_b = 32'hBEEF_1234;
        step();
        iv_b = 1'b0;
        chk("s0_valid", 1, 160'(ov_b), 160'(1));
        chk("s0_data", 1, 160'(od_b), 160'(32'hBEEF_1234));
        chk("s0_ready_full", 1, 160'(irdy_b), 160'(0));
        ordy_b = 1'b1;
        #1;
        chk("s0_ready_follow", 1, 160'(irdy_b), 160'(1));
        step();
        chk("s0_empty", 1, 160'(ov_b), 160'(0));
        ordy_a = 1'b1;
        repeat (10000) begin
            iv_a = 1'($urandom_range(0, 1));
            ordy_a = 1'($urandom_range(0, 1));
            flush_a = $urandom_range(0, 63) == 0;
            id_a = {$urandom, $urandom, $urandom, $urandom, $urandom};
            iv_b = 1'($urandom_range(0, 1));
            ordy_b = 1'($urandom_range(0, 1));
            flush_b = $urandom_range(0, 63) == 0;
            id_b = $urandom;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
